// File: rtl/serial_add_ctrl.sv
// Operand driver and result collector for an external bit-serial adder.
// Shifts two W-bit operands out LSB-first (plus a carry-flush bit) and gathers the sum stream.
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         add_clr,
    output logic         ser_a,
    output logic         ser_b,
    input  logic         ser_s,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W:0]   result
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLR   = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sh_a;
    logic [W-1:0]  sh_b;

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
            add_clr <= 1'b0;
            ser_a   <= 1'b0;
            ser_b   <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_valid) begin
                        sh_a    <= op_a;
                        sh_b    <= op_b;
                        add_clr <= 1'b1;
                        ser_a   <= 1'b0;
                        ser_b   <= 1'b0;
                        state   <= CLR;
                    end
                end
                CLR: begin
                    add_clr <= 1'b0;
                    ser_a   <= sh_a[0];
                    ser_b   <= sh_b[0];
                    sh_a    <= sh_a >> 1;
                    sh_b    <= sh_b >> 1;
                    cnt     <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    // The adder's registered output lags the driven bit by two edges,
                    // so nothing valid arrives until cnt=1.
                    if (cnt != '0)
                        result <= {ser_s, result[W:1]};
                    if (cnt == CNT_LAST) begin
                        ser_a <= 1'b0;
                        ser_b <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        // After W shifts the registers are all zero, which supplies the flush bit.
                        ser_a <= sh_a[0];
                        ser_b <= sh_b[0];
                        sh_a  <= sh_a >> 1;
                        sh_b  <= sh_b >> 1;
                        cnt   <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    ser_a  <= 1'b0;
                    ser_b  <= 1'b0;
                    result <= {ser_s, result[W:1]};
                    state  <= DONE;
                end
                DONE: begin
                    ser_a   <= 1'b0;
                    ser_b   <= 1'b0;
                    add_clr <= 1'b0;
                    if (res_ready)
                        state <= IDLE;
                end
                default: begin
                    add_clr <= 1'b0;
                    ser_a   <= 1'b0;
                    ser_b   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl wired to a behavioural serial adder.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         add_clr;
    logic         ser_a;
    logic         ser_b;
    logic         ser_s;
    logic         res_valid;
    logic         res_ready;
    logic [W:0]   result;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.W(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .add_clr     (add_clr),
        .ser_a       (ser_a),
        .ser_b       (ser_b),
        .ser_s       (ser_s),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial adder: registered sum bit, carry state, active-high synchronous clear.
    logic s_q;
    logic c_q;
    always_ff @(posedge clk) begin
        if (add_clr) begin
            s_q <= 1'b0;
            c_q <= 1'b0;
        end else begin
            s_q <= ser_a ^ ser_b ^ c_q;
            c_q <= (ser_a & ser_b) | (c_q & (ser_a ^ ser_b));
        end
    end
    assign ser_s = s_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation from accept to result; checks latency, sum and the clear pulse.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] exp, input string tag, input bit consume);
        int n;
        int clr_n;
        n = 0;
        while (!start_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        op_a = a;
        op_b = b;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        op_a = W'($urandom);
        op_b = W'($urandom);
        clr_n = 0;
        n = 0;
        while (!res_valid && n < 50) begin
            if (add_clr) clr_n++;
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd11);
        chk({tag, "_result"}, 32'(result), 32'(exp));
        chk({tag, "_clr_pulses"}, 32'(clr_n), 32'd1);
        if (consume) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
            chk({tag, "_ready_back"}, 32'(start_ready), 32'd1);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        reset_n     = 1'b0;
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        res_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_add_clr", 32'(add_clr), 32'd0);
        chk("rst_ser_a", 32'(ser_a), 32'd0);
        chk("rst_ser_b", 32'(ser_b), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'h5A, 8'h3C, 9'h096, "t1", 1'b1);
        do_op(8'hFF, 8'h01, 9'h100, "t2", 1'b1);
        do_op(8'hFF, 8'hFF, 9'h1FE, "t3a", 1'b1);
        do_op(8'h00, 8'h00, 9'h000, "t3b", 1'b1);

        // Consumer stalls in DONE; a start pulse during the stall must be ignored.
        res_ready = 1'b0;
        do_op(8'h81, 8'h7E, 9'h0FF, "t4", 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                op_a = 8'h11;
                op_b = 8'h22;
                start_valid = 1'b1;
            end
            @(posedge clk); #1;
            start_valid = 1'b0;
            chk("t4_hold_valid", 32'(res_valid), 32'd1);
            chk("t4_hold_result", 32'(result), 32'h0FF);
            chk("t4_hold_start_ready", 32'(start_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_valid_drop", 32'(res_valid), 32'd0);
        chk("t4_ready_back", 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        chk("t4_no_accept", 32'(start_ready), 32'd1);

        // Abort mid-SHIFT at cnt=4.
        op_a = 8'hAA;
        op_b = 8'h55;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_start_ready", 32'(start_ready), 32'd1);
        chk("t5_add_clr", 32'(add_clr), 32'd0);
        chk("t5_ser_a", 32'(ser_a), 32'd0);
        chk("t5_ser_b", 32'(ser_b), 32'd0);
        chk("t5_res_valid", 32'(res_valid), 32'd0);
        chk("t5_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'h12, 8'h34, 9'h046, "t5", 1'b1);

        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, {1'b0, ra} + {1'b0, rb}, "t6", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
